// File: rtl/func_ret_reorder_pkg.sv
// ---------------------------------------------------------------------------
// func_ret_reorder_pkg
//   Constants and types shared between the caller-side return reorder buffer
//   and the function-arbiter return path.
//
//   CALL_SEQ_W : width of a call sequence tag
//   ROB_W      : number of reorder entries (one per tag value)
//   RET_DW     : width of a return value
//   PTR_W      : tag width plus one wrap bit, used for alloc/head pointers
//   ret_pkt_t  : a tagged return packet as carried by the return network
// ---------------------------------------------------------------------------
package func_ret_reorder_pkg;

  localparam int CALL_SEQ_W = 2;
  localparam int ROB_W      = 1 << CALL_SEQ_W;
  localparam int RET_DW     = 32;
  localparam int PTR_W      = CALL_SEQ_W + 1;

  typedef logic [CALL_SEQ_W-1:0] call_seq_t;
  typedef logic [PTR_W-1:0]      rob_ptr_t;

  typedef struct packed {
    logic [CALL_SEQ_W-1:0] seq;
    logic [RET_DW-1:0]     data;
  } ret_pkt_t;

endpackage

// File: rtl/func_ret_reorder.sv
// ---------------------------------------------------------------------------
// func_ret_reorder
//   Caller-side return reorder buffer. Every accepted call is given the next
//   sequence tag; tagged returns arriving in any order are parked in the
//   matching entry and handed back to the caller strictly in issue order.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rstn         asynchronous active-low reset
//   call_valid   caller wants to issue a call
//   call_ready   a tag is free (fewer than ROB_W calls outstanding)
//   call_seq     tag given to the call accepted this cycle
//   ret_valid    return packet present, always accepted
//   ret_seq      tag of the returning call
//   ret_data     return value
//   out_valid    the oldest outstanding call has its return available
//   out_ready    caller consumes the return
//   out_seq      tag of the delivered return
//   out_data     delivered return value
//   outstanding  calls issued and not yet delivered
//   err_unexp    one-cycle pulse: a return for a tag not pending or already
//                filled was dropped on the previous cycle
// ---------------------------------------------------------------------------
module func_ret_reorder
  import func_ret_reorder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  call_valid,
  output logic                  call_ready,
  output logic [CALL_SEQ_W-1:0] call_seq,
  input  logic                  ret_valid,
  input  logic [CALL_SEQ_W-1:0] ret_seq,
  input  logic [RET_DW-1:0]     ret_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CALL_SEQ_W-1:0] out_seq,
  output logic [RET_DW-1:0]     out_data,
  output logic [CALL_SEQ_W:0]   outstanding,
  output logic                  err_unexp
);

  rob_ptr_t          alloc_ptr;
  rob_ptr_t          head_ptr;
  logic [ROB_W-1:0]  pending;
  logic [ROB_W-1:0]  done;
  logic [RET_DW-1:0] data_q [ROB_W];

  call_seq_t alloc_idx;
  call_seq_t head_idx;
  logic      call_accept;
  logic      ret_accept;
  logic      pop;

  // The wrap bit makes alloc_ptr - head_ptr range over 0..ROB_W, so full and
  // empty are distinguishable. call_ready depends only on registered state,
  // so a pop in the same cycle never frees a slot for a call.
  assign alloc_idx   = alloc_ptr[CALL_SEQ_W-1:0];
  assign head_idx    = head_ptr[CALL_SEQ_W-1:0];
  assign outstanding = alloc_ptr - head_ptr;
  assign call_ready  = (outstanding != PTR_W'(ROB_W));
  assign call_seq    = alloc_idx;

  // A return is kept only for a tag that is waiting and not yet filled.
  // A head slot being popped is already done, so a return to it this cycle
  // is rejected as unexpected.
  assign call_accept = call_valid && call_ready;
  assign ret_accept  = ret_valid && pending[ret_seq] && !done[ret_seq];

  assign out_valid = done[head_idx];
  assign out_seq   = head_idx;
  assign out_data  = data_q[head_idx];
  assign pop       = out_valid && out_ready;

  // Call, return and pop always touch different slots (a call cannot target
  // the head while full, a return cannot target a done slot), so each update
  // is written independently and none of them override each other.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alloc_ptr <= '0;
      head_ptr  <= '0;
      pending   <= '0;
      done      <= '0;
      err_unexp <= 1'b0;
      for (int i = 0; i < ROB_W; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      err_unexp <= ret_valid && !ret_accept;

      if (call_accept) begin
        pending[alloc_idx] <= 1'b1;
        alloc_ptr          <= alloc_ptr + PTR_W'(1);
      end

      if (ret_accept) begin
        data_q[ret_seq] <= ret_data;
        done[ret_seq]   <= 1'b1;
      end

      if (pop) begin
        pending[head_idx] <= 1'b0;
        done[head_idx]    <= 1'b0;
        head_ptr          <= head_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_func_ret_reorder.sv
// ---------------------------------------------------------------------------
// tb_func_ret_reorder
//   Directed bench for the return reorder buffer: in-order and reordered
//   returns, full/pop/call interaction with wrap, backpressure, unexpected
//   and duplicate returns, and asynchronous reset mid-operation.
// ---------------------------------------------------------------------------
module tb_func_ret_reorder;

  import func_ret_reorder_pkg::*;

  logic                  clk;
  logic                  rstn;
  logic                  call_valid;
  logic                  call_ready;
  logic [CALL_SEQ_W-1:0] call_seq;
  logic                  ret_valid;
  logic [CALL_SEQ_W-1:0] ret_seq;
  logic [RET_DW-1:0]     ret_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CALL_SEQ_W-1:0] out_seq;
  logic [RET_DW-1:0]     out_data;
  logic [CALL_SEQ_W:0]   outstanding;
  logic                  err_unexp;

  int checks = 0;
  int errors = 0;

  func_ret_reorder dut (
    .clk        (clk),
    .rstn       (rstn),
    .call_valid (call_valid),
    .call_ready (call_ready),
    .call_seq   (call_seq),
    .ret_valid  (ret_valid),
    .ret_seq    (ret_seq),
    .ret_data   (ret_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_seq    (out_seq),
    .out_data   (out_data),
    .outstanding(outstanding),
    .err_unexp  (err_unexp)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always terminates
  initial begin
    #20000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  // Drive one cycle of inputs at the falling edge, let the rising edge
  // consume them, and return at the next falling edge for sampling.
  task automatic applyStimulus(input logic cv, input logic rv,
                               input logic [CALL_SEQ_W-1:0] rs,
                               input logic [RET_DW-1:0] rd, input logic ordy);
    call_valid = cv;
    ret_valid  = rv;
    ret_seq    = rs;
    ret_data   = rd;
    out_ready  = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One comparison: count it, and on mismatch count and report the failure
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".call_ready"},  64'(call_ready),  64'd1);
    checkOutput({tag, ".call_seq"},    64'(call_seq),    64'd0);
    checkOutput({tag, ".out_valid"},   64'(out_valid),   64'd0);
    checkOutput({tag, ".out_seq"},     64'(out_seq),     64'd0);
    checkOutput({tag, ".out_data"},    64'(out_data),    64'd0);
    checkOutput({tag, ".outstanding"}, 64'(outstanding), 64'd0);
    checkOutput({tag, ".err_unexp"},   64'(err_unexp),   64'd0);
  endtask

  initial begin
    rstn       = 1'b0;
    call_valid = 1'b0;
    ret_valid  = 1'b0;
    ret_seq    = '0;
    ret_data   = '0;
    out_ready  = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    // ---------------- in-order ----------------
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("inord.call_seq%0d", i), 64'(call_seq), 64'(i));
      checkOutput($sformatf("inord.call_ready%0d", i), 64'(call_ready), 64'd1);
      applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
    end
    checkOutput("inord.full_ready", 64'(call_ready), 64'd0);
    checkOutput("inord.full_outst", 64'(outstanding), 64'd4);
    checkOutput("inord.no_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'hA0, 1'b0);
    checkOutput("inord.lat_valid", 64'(out_valid), 64'd1);
    checkOutput("inord.lat_data", 64'(out_data), 64'hA0);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 2'(i), 32'hA0 + 32'(i), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("inord.valid%0d", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("inord.seq%0d", i), 64'(out_seq), 64'(i));
      checkOutput($sformatf("inord.data%0d", i), 64'(out_data), 64'hA0 + 64'(i));
      applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
    end
    checkOutput("inord.empty_valid", 64'(out_valid), 64'd0);
    checkOutput("inord.empty_outst", 64'(outstanding), 64'd0);
    checkOutput("inord.empty_ready", 64'(call_ready), 64'd1);

    // ---------------- reorder (tags wrap back to 0) ----------------
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("reord.call_seq%0d", i), 64'(call_seq), 64'(i));
      applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 2'd3, 32'hD3, 1'b1);
    checkOutput("reord.wait3", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, 1'b1, 2'd1, 32'hD1, 1'b1);
    checkOutput("reord.wait1", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, 1'b1, 2'd2, 32'hD2, 1'b1);
    checkOutput("reord.wait2", 64'(out_valid), 64'd0);
    checkOutput("reord.no_err", 64'(err_unexp), 64'd0);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'hD0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("reord.valid%0d", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("reord.seq%0d", i), 64'(out_seq), 64'(i));
      checkOutput($sformatf("reord.data%0d", i), 64'(out_data), 64'hD0 + 64'(i));
      applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
    end
    checkOutput("reord.empty_valid", 64'(out_valid), 64'd0);

    // ---------------- full with simultaneous pop and call ----------------
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h55, 1'b0);
    checkOutput("full.outst4", 64'(outstanding), 64'd4);
    checkOutput("full.ready0", 64'(call_ready), 64'd0);
    checkOutput("full.head_valid", 64'(out_valid), 64'd1);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b1);
    checkOutput("full.outst3", 64'(outstanding), 64'd3);
    checkOutput("full.ready1", 64'(call_ready), 64'd1);
    checkOutput("full.wrap_seq", 64'(call_seq), 64'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
    checkOutput("full.outst4b", 64'(outstanding), 64'd4);
    checkOutput("full.next_seq", 64'(call_seq), 64'd1);

    // ---------------- backpressure (head is tag 1) ----------------
    applyStimulus(1'b0, 1'b1, 2'd1, 32'hB1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp.valid%0d", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("bp.seq%0d", i), 64'(out_seq), 64'd1);
      checkOutput($sformatf("bp.data%0d", i), 64'(out_data), 64'hB1);
      if (i == 2) applyStimulus(1'b0, 1'b1, 2'd2, 32'hB2, 1'b0);
      else        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    end
    checkOutput("bp.no_err", 64'(err_unexp), 64'd0);

    // ---------------- duplicate return for a done tag ----------------
    applyStimulus(1'b0, 1'b1, 2'd1, 32'hEE, 1'b0);
    checkOutput("dup.err", 64'(err_unexp), 64'd1);
    checkOutput("dup.data_kept", 64'(out_data), 64'hB1);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    checkOutput("dup.err_pulse", 64'(err_unexp), 64'd0);
    checkOutput("dup.outst", 64'(outstanding), 64'd4);

    // ---------------- reset mid-operation: 3 outstanding, 1 done ----------------
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
    checkOutput("mid.outst3", 64'(outstanding), 64'd3);
    checkOutput("mid.seq2", 64'(out_seq), 64'd2);
    checkOutput("mid.data2", 64'(out_data), 64'hB2);
    call_valid = 1'b0;
    ret_valid  = 1'b0;
    out_ready  = 1'b0;
    rstn       = 1'b0;
    #1;
    checkResetOutputs("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // ---------------- unexpected return with nothing outstanding ----------------
    applyStimulus(1'b0, 1'b1, 2'd2, 32'h77, 1'b0);
    checkOutput("unexp.err", 64'(err_unexp), 64'd1);
    checkOutput("unexp.valid", 64'(out_valid), 64'd0);
    checkOutput("unexp.outst", 64'(outstanding), 64'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    checkOutput("unexp.err_pulse", 64'(err_unexp), 64'd0);
    checkOutput("unexp.valid2", 64'(out_valid), 64'd0);

    // ---------------- first call after reset gets tag 0 ----------------
    checkOutput("post.call_seq", 64'(call_seq), 64'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
    checkOutput("post.outst", 64'(outstanding), 64'd1);
    checkOutput("post.next_seq", 64'(call_seq), 64'd1);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h1234, 1'b0);
    checkOutput("post.valid", 64'(out_valid), 64'd1);
    checkOutput("post.data", 64'(out_data), 64'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/func_ret_reorder.md
# func_ret_reorder

Caller-side return reorder buffer for the function-arbiter call path. It hands out a call sequence tag for every call a caller issues. Tagged return values arrive out of order from the arbiter's return network. The block stores them and delivers them to the caller strictly in issue order. One instance sits per caller, between the caller's call/return ports and the arbiter.

## Interface
- RET_DW, 32, return value width
- CALL_SEQ_W, 2, sequence tag width; ROB_W = 1<<CALL_SEQ_W entries
- clk  in  1  clock; all state on rising edge
- rstn  in  1  asynchronous active-low reset
- call_valid  in  1  caller wants to issue a call
- call_ready  out  1  tag available (outstanding < ROB_W)
- call_seq  out  CALL_SEQ_W  tag assigned to the call accepted this cycle
- ret_valid  in  1  return packet present; always accepted, no backpressure
- ret_seq  in  CALL_SEQ_W  tag of returning call
- ret_data  in  RET_DW  return value
- out_valid  out  1  in-order return available
- out_ready  in  1  caller consumes return
- out_seq  out  CALL_SEQ_W  tag of delivered return
- out_data  out  RET_DW  delivered return value
- outstanding  out  CALL_SEQ_W+1  calls issued and not yet delivered
- err_unexp  out  1  one-cycle pulse: return for a tag not pending, or already filled

## Operation
- State:
  - alloc_ptr and head_ptr, each CALL_SEQ_W+1 bits with a wrap bit.
  - Per-entry pending[ROB_W] and done[ROB_W] bits.
  - data[ROB_W][RET_DW] array.
- outstanding = alloc_ptr − head_ptr, computed modulo 2^(CALL_SEQ_W+1).
- call_ready = (outstanding != ROB_W). It is computed from registered state only, so a pop in the same cycle does not free a slot for a call.
- call_seq = alloc_ptr[CALL_SEQ_W-1:0]. It is driven continuously and valid whenever call_ready is high.
- Call accept (call_valid && call_ready): pending[alloc] ← 1 and alloc_ptr++.
- Return (ret_valid):
  - If pending[ret_seq] && !done[ret_seq]: data[ret_seq] ← ret_data and done[ret_seq] ← 1.
  - Otherwise the packet is dropped, no state changes, and err_unexp = 1 on the next cycle.
- out_valid = done[head]. out_seq = head_ptr[CALL_SEQ_W-1:0]. out_data = data[head].
- Pop (out_valid && out_ready): pending[head] ← 0, done[head] ← 0, head_ptr++.
- Simultaneous events:
  - A call, a return, and a pop may all occur in one cycle, and each takes effect independently.
  - A return to the head slot in the same cycle as a pop of that slot cannot happen legally; the slot is done, so that return flags err_unexp.
  - A call to a slot being popped in the same cycle cannot happen, because call_ready is low when full.
- Wrap: pointers wrap naturally and the wrap bit distinguishes full from empty.
- Reset (asynchronous, any time): pointers 0, all pending/done 0, data 0, err_unexp 0. Outstanding calls are lost, and the caller must not expect their returns.

## Timing
- Reset values: call_ready 1, call_seq 0, out_valid 0, out_seq 0, out_data 0, outstanding 0, err_unexp 0.
- ret_valid to out_valid: minimum 1 cycle, when the return is for the head tag.
- Pop to next out_valid: 1 cycle if the next entry is already done; back-to-back pops are sustained at 1 per cycle.
- out_seq and out_data hold stable while out_valid && !out_ready.
- Call accept to outstanding update: 1 cycle. err_unexp is a registered 1-cycle pulse.

## Structure
- Shared package (alongside the existing function-arbiter constants):
  - CALL_SEQ_W, ROB_W and RET_DW.
  - A typedef ret_pkt_t {seq[CALL_SEQ_W], data[RET_DW]} shared with the arbiter return path.
- No sub-module is needed. Entries are flat register arrays indexed by pointer, with no FIFO instance.

## Test plan
- In-order: 4 calls get tags 0,1,2,3 and call_ready drops after the 4th. Returns arrive for 0,1,2,3 with data 0xA0..0xA3. Output is 0xA0..0xA3 in order, one per cycle with out_ready=1.
- Reorder: calls with tags 0..3, returns arrive in order 3,1,2,0 with data 0xD3,0xD1,0xD2,0xD0. out_valid stays 0 until tag 0 arrives, then the block delivers 0xD0,0xD1,0xD2,0xD3 on 4 consecutive cycles.
- Full plus simultaneous pop and call: with 4 outstanding and head done, assert call_valid and out_ready together. The pop happens, the call is refused that cycle, and it is accepted next cycle with tag 0 after wrap; outstanding goes 4→3→4.
- Backpressure: with head done and out_ready=0 for 5 cycles, out_data and out_seq stay constant. A later return for the head+1 tag does not change the output.
- Unexpected return: ret_valid with ret_seq=2 while no calls are outstanding produces err_unexp high for exactly 1 cycle, no out_valid, and outstanding unchanged. A duplicate return for a done tag also produces err_unexp, and the original data is retained.
- Reset mid-operation: with 3 outstanding and 1 done, deasserting rstn returns every output to its reset value immediately. The next call after release gets tag 0.
